// File: rtl/switch_pkg.sv
// Shared types and constants for the 4-port switch ingress path.
package switch_pkg;

  localparam int NUM_PORTS = 4;
  localparam int HDR_BYTES = 3;
  localparam int FCS_BYTES = 1;
  localparam int CNT_W     = 9;
  localparam logic [7:0] ADDR_RST = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SA,
    S_LEN,
    S_PAYLOAD,
    S_FCS,
    S_DISCARD
  } state_t;

endpackage

// File: rtl/switch_addr_table.sv
// Per-port address registers with a write port and a
// combinational lowest-index DA match.
module switch_addr_table
  import switch_pkg::*;
#(
  parameter int         N   = switch_pkg::NUM_PORTS,
  parameter logic [7:0] RST = switch_pkg::ADDR_RST
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [$clog2(N)-1:0] wr_idx,
  input  logic [7:0]           wr_data,
  input  logic [7:0]           da,
  output logic                 hit,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  logic [7:0] tbl [N];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) tbl[i] <= RST;
    end else if (wr_en) begin
      tbl[wr_idx] <= wr_data;
    end
  end

  // Scan high to low so the lowest matching index is left standing.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (tbl[i] == da) begin
        hit = 1'b1;
        idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/switch_ingress.sv
// Ingress parser: DA lookup, cut-through routing, FCS check
// and good/drop packet counters.
module switch_ingress
  import switch_pkg::*;
#(
  parameter int         NUM_PORTS = switch_pkg::NUM_PORTS,
  parameter logic [7:0] ADDR_RST  = switch_pkg::ADDR_RST
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         data_status,
  input  logic [7:0]                   data,
  input  logic                         mem_en,
  input  logic                         mem_rd_wr,
  input  logic [$clog2(NUM_PORTS)-1:0] mem_add,
  input  logic [7:0]                   mem_data,
  output logic                         out_valid,
  output logic [7:0]                   out_data,
  output logic [$clog2(NUM_PORTS)-1:0] out_port,
  output logic                         out_sop,
  output logic                         out_eop,
  output logic                         out_err,
  output logic                         out_abort,
  output logic [7:0]                   pkt_count,
  output logic [7:0]                   drop_count
);

  localparam int PW = $clog2(NUM_PORTS);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       xor_q, xor_d;
  logic             hit;
  logic [PW-1:0]    hit_idx;

  logic          valid_d, sop_d, eop_d;
  logic          err_d, abort_d;
  logic [7:0]    data_d;
  logic [PW-1:0] port_d;
  logic          pkt_inc, drop_inc;
  logic          in_pkt;

  switch_addr_table #(
    .N   (NUM_PORTS),
    .RST (ADDR_RST)
  ) u_table (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (mem_en & mem_rd_wr),
    .wr_idx  (mem_add),
    .wr_data (mem_data),
    .da      (data),
    .hit     (hit),
    .idx     (hit_idx)
  );

  assign in_pkt = (state_q == S_SA) || (state_q == S_LEN)
               || (state_q == S_PAYLOAD) || (state_q == S_FCS);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    xor_d    = xor_q;
    port_d   = out_port;
    valid_d  = 1'b0;
    sop_d    = 1'b0;
    eop_d    = 1'b0;
    err_d    = 1'b0;
    abort_d  = 1'b0;
    pkt_inc  = 1'b0;
    drop_inc = 1'b0;
    if (in_pkt && !data_status) begin
      abort_d  = 1'b1;
      drop_inc = 1'b1;
      state_d  = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (data_status) begin
            if (hit) begin
              valid_d = 1'b1;
              sop_d   = 1'b1;
              port_d  = hit_idx;
              xor_d   = data;
              cnt_d   = CNT_W'(HDR_BYTES - 1);
              state_d = S_SA;
            end else begin
              drop_inc = 1'b1;
              state_d  = S_DISCARD;
            end
          end
        end
        S_SA: begin
          valid_d = 1'b1;
          xor_d   = xor_q ^ data;
          cnt_d   = cnt_q - 1'b1;
          state_d = S_LEN;
        end
        S_LEN: begin
          valid_d = 1'b1;
          if (data == 8'h00) begin
            eop_d    = 1'b1;
            err_d    = 1'b1;
            drop_inc = 1'b1;
            state_d  = S_DISCARD;
          end else begin
            xor_d   = xor_q ^ data;
            cnt_d   = CNT_W'(data) + CNT_W'(FCS_BYTES);
            state_d = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          valid_d = 1'b1;
          xor_d   = xor_q ^ data;
          cnt_d   = cnt_q - 1'b1;
          // Only the FCS byte remains once this one is taken.
          if (cnt_q == CNT_W'(FCS_BYTES + 1)) state_d = S_FCS;
        end
        S_FCS: begin
          valid_d  = 1'b1;
          eop_d    = 1'b1;
          err_d    = (xor_q != data);
          pkt_inc  = (xor_q == data);
          drop_inc = (xor_q != data);
          state_d  = S_DISCARD;
        end
        S_DISCARD: begin
          if (!data_status) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    data_d = valid_d ? data : 8'h00;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      xor_q      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_port   <= '0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_err    <= 1'b0;
      out_abort  <= 1'b0;
      pkt_count  <= '0;
      drop_count <= '0;
    end else begin
      cnt_q     <= cnt_d;
      xor_q     <= xor_d;
      out_valid <= valid_d;
      out_data  <= data_d;
      out_port  <= port_d;
      out_sop   <= sop_d;
      out_eop   <= eop_d;
      out_err   <= err_d;
      out_abort <= abort_d;
      if (pkt_inc)  pkt_count  <= pkt_count + 8'd1;
      if (drop_inc) drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_switch_ingress.sv
// Directed bench for switch_ingress: routing, FCS, miss,
// truncation, LEN=0, mid-packet reset and counter wrap.
module tb_switch_ingress;

  logic       clk = 1'b0;
  logic       reset;
  logic       data_status;
  logic [7:0] data;
  logic       mem_en;
  logic       mem_rd_wr;
  logic [1:0] mem_add;
  logic [7:0] mem_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_port;
  logic       out_sop;
  logic       out_eop;
  logic       out_err;
  logic       out_abort;
  logic [7:0] pkt_count;
  logic [7:0] drop_count;

  switch_ingress dut (
    .clk         (clk),
    .reset       (reset),
    .data_status (data_status),
    .data        (data),
    .mem_en      (mem_en),
    .mem_rd_wr   (mem_rd_wr),
    .mem_add     (mem_add),
    .mem_data    (mem_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_port    (out_port),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .out_err     (out_err),
    .out_abort   (out_abort),
    .pkt_count   (pkt_count),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  int         nval, nsop, neop, nabort;
  int         abort_valid, data_bad;
  logic [7:0] sop_data, eop_data;
  logic       eop_err;
  logic [1:0] port_seen;
  logic [7:0] outq [$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input logic ds, input logic [7:0] d);
    data_status = ds;
    data        = d;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] v,
                    input logic w);
    mem_en    = 1'b1;
    mem_rd_wr = w;
    mem_add   = a;
    mem_data  = v;
    @(posedge clk);
    #1;
    mem_en    = 1'b0;
    mem_rd_wr = 1'b0;
  endtask

  task automatic sample();
    if (out_valid) begin
      if (nval == 0) port_seen = out_port;
      nval++;
      outq.push_back(out_data);
    end
    if (out_sop) begin
      nsop++;
      sop_data = out_data;
    end
    if (out_eop) begin
      neop++;
      eop_data = out_data;
      eop_err  = out_err;
    end
    if (out_abort) begin
      nabort++;
      if (out_valid) abort_valid++;
    end
  endtask

  // Send n bytes back to back, then two idle cycles.
  task automatic tx(input logic [7:0] b [8], input int n);
    nval = 0; nsop = 0; neop = 0; nabort = 0;
    abort_valid = 0; data_bad = 0;
    sop_data = 8'h00; eop_data = 8'h00; eop_err = 1'b0;
    port_seen = 2'd0;
    outq.delete();
    for (int i = 0; i < n; i++) begin
      step(1'b1, b[i]);
      sample();
    end
    repeat (2) begin
      step(1'b0, 8'h00);
      sample();
    end
    for (int i = 0; i < nval; i++)
      if (i >= n || outq[i] !== b[i]) data_bad++;
  endtask

  initial begin
    reset       = 1'b1;
    data_status = 1'b0;
    data        = 8'h00;
    mem_en      = 1'b0;
    mem_rd_wr   = 1'b0;
    mem_add     = 2'd0;
    mem_data    = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data",  out_data, 0);
    chk("rst_port",  out_port, 0);
    chk("rst_sop",   out_sop, 0);
    chk("rst_eop",   out_eop, 0);
    chk("rst_err",   out_err, 0);
    chk("rst_abort", out_abort, 0);
    chk("rst_pkt",   pkt_count, 0);
    chk("rst_drop",  drop_count, 0);
    reset = 1'b0;
    step(1'b0, 8'h00);

    // Good packet to port 1.
    wr(2'd1, 8'hA5, 1'b1);
    tx('{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h95,
         8'h00, 8'h00}, 6);
    chk("A_nval", nval, 6);
    chk("A_port", port_seen, 1);
    chk("A_nsop", nsop, 1);
    chk("A_sopd", sop_data, 8'hA5);
    chk("A_neop", neop, 1);
    chk("A_eopd", eop_data, 8'h95);
    chk("A_err",  eop_err, 0);
    chk("A_data", data_bad, 0);
    chk("A_abrt", nabort, 0);
    chk("A_pkt",  pkt_count, 1);
    chk("A_drop", drop_count, 0);

    // Bad FCS.
    tx('{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h94,
         8'h00, 8'h00}, 6);
    chk("B_nval", nval, 6);
    chk("B_neop", neop, 1);
    chk("B_err",  eop_err, 1);
    chk("B_pkt",  pkt_count, 1);
    chk("B_drop", drop_count, 1);

    // Table {00,00,00,A5}; a read must not write.
    wr(2'd1, 8'h00, 1'b1);
    wr(2'd3, 8'hA5, 1'b1);
    wr(2'd2, 8'h77, 1'b0);
    tx('{8'h77, 8'h01, 8'h02, 8'h11, 8'h22, 8'h95,
         8'h00, 8'h00}, 6);
    chk("C_nval", nval, 0);
    chk("C_drop", drop_count, 2);
    chk("C_pkt",  pkt_count, 1);
    tx('{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h95,
         8'h00, 8'h00}, 6);
    chk("C2_nval", nval, 6);
    chk("C2_port", port_seen, 3);
    chk("C2_err",  eop_err, 0);
    chk("C2_pkt",  pkt_count, 2);

    // Truncated after 2 of 4 payload bytes.
    tx('{8'h00, 8'h01, 8'h04, 8'h10, 8'h20, 8'h00,
         8'h00, 8'h00}, 5);
    chk("D_nval", nval, 5);
    chk("D_port", port_seen, 0);
    chk("D_abrt", nabort, 1);
    chk("D_abv",  abort_valid, 0);
    chk("D_neop", neop, 0);
    chk("D_data", data_bad, 0);
    chk("D_drop", drop_count, 3);
    chk("D_pkt",  pkt_count, 2);
    tx('{8'h00, 8'h01, 8'h02, 8'h33, 8'h44, 8'h74,
         8'h00, 8'h00}, 6);
    chk("D2_nval", nval, 6);
    chk("D2_port", port_seen, 0);
    chk("D2_err",  eop_err, 0);
    chk("D2_pkt",  pkt_count, 3);

    // LEN = 0: error on the LEN byte, rest ignored.
    tx('{8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33,
         8'h00, 8'h00}, 6);
    chk("E_nval", nval, 3);
    chk("E_neop", neop, 1);
    chk("E_eopd", eop_data, 8'h00);
    chk("E_err",  eop_err, 1);
    chk("E_drop", drop_count, 4);
    chk("E_pkt",  pkt_count, 3);

    // Reset mid-payload.
    step(1'b1, 8'h00);
    step(1'b1, 8'h01);
    step(1'b1, 8'h03);
    step(1'b1, 8'h55);
    chk("F_pre_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    chk("F_valid", out_valid, 0);
    chk("F_data",  out_data, 0);
    chk("F_pkt",   pkt_count, 0);
    chk("F_drop",  drop_count, 0);
    data_status = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b0, 8'h00);
    chk("F_eop",   out_eop, 0);
    chk("F_abrt",  out_abort, 0);
    tx('{8'h00, 8'h01, 8'h01, 8'h5A, 8'h5A, 8'h00,
         8'h00, 8'h00}, 5);
    chk("F2_nval", nval, 5);
    chk("F2_port", port_seen, 0);
    chk("F2_err",  eop_err, 0);
    chk("F2_pkt",  pkt_count, 1);
    tx('{8'hA5, 8'h01, 8'h01, 8'h5A, 8'hFF, 8'h00,
         8'h00, 8'h00}, 5);
    chk("F3_nval", nval, 0);
    chk("F3_drop", drop_count, 1);

    // 255 more misses wrap the drop counter to zero.
    for (int i = 0; i < 255; i++) begin
      step(1'b1, 8'h3C);
      step(1'b0, 8'h00);
    end
    step(1'b0, 8'h00);
    chk("G_wrap", drop_count, 0);
    chk("G_pkt",  pkt_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
